metronome_bar: RTL
==================

METRONOME_BAR -- requirements
Module: metronome_bar

Interface
REQ-001 Param CLK_HZ, 50_000_000, clock frequency in Hz.
REQ-002 Param BPM_MIN, 30, lowest tempo.
REQ-003 Param BPM_MAX, 300, highest tempo.
REQ-004 Param BPM_DEFAULT, 120, tempo after reset.
REQ-005 Param BEATS_MAX, 8, maximum beats per bar.
REQ-006 Param CNT_W, 34, beat-period counter width.
REQ-007 i_clk  in  1  single clock; all logic on its rising edge.
REQ-008 i_reset_n  in  1  reset, asynchronous, active-low.
REQ-009 i_run  in  1  level; 1 = metronome running, 0 = stopped.
REQ-010 i_bpm_plus_1 / i_bpm_plus_5 / i_bpm_minus_1 / i_bpm_minus_5  in  1 each  single-cycle debounced tempo-step pulses.
REQ-011 i_beats_sel  in  4  requested beats per bar.
REQ-012 o_trigger  out  1  one-cycle pulse per beat.
REQ-013 o_accent  out  1  one-cycle pulse coincident with o_trigger on beat 0 only.
REQ-014 o_beat_idx  out  4  index of the current beat, 0..beats-1.
REQ-015 o_bpm  out  9  current tempo.
REQ-016 o_bpm_counter  out  CNT_W  active beat period in clock cycles.
REQ-017 o_busy  out  1  high while a period recomputation is in progress.

Function
REQ-018 Tempo step: one step per cycle, priority plus_5 > plus_1 > minus_5 > minus_1; result saturates at BPM_MIN / BPM_MAX.
REQ-019 Every tempo change starts a period computation: CLK_HZ*60 / o_bpm, integer floor, on a sequential restoring divider.
REQ-020 Divider latency: exactly CNT_W+1 cycles from start to done; o_busy high for that whole window.
REQ-021 A tempo change while o_busy is high sets a pending flag; on done, the divider restarts immediately with the latest o_bpm; only the final result is used.
REQ-022 Divider result goes into a staged period register; o_bpm_counter takes the staged value only at the next beat boundary, or immediately when stopped.
REQ-023 States STOP and RUN; reset enters STOP.
REQ-024 STOP->RUN on i_run=1: o_trigger and o_accent pulse in the next cycle, o_beat_idx=0, phase counter cleared.
REQ-025 RUN: phase counter counts 0..o_bpm_counter-1; on terminal count it wraps to 0, o_trigger pulses, and o_beat_idx advances.
REQ-026 o_beat_idx wraps to 0 after beats-1; o_accent pulses on that wrap.
REQ-027 beats latched from i_beats_sel only at a bar boundary (beat 0) or in STOP; value 0 is treated as 1; values above BEATS_MAX clamp to BEATS_MAX.
REQ-028 beats=1: every trigger is an accent.
REQ-029 RUN->STOP on i_run=0: outputs go quiet in the same cycle, phase and beat index clear, and the divider keeps running.
REQ-030 Tempo buttons are honoured in both states.

Reset
REQ-031 Asserted: o_trigger=0, o_accent=0, o_beat_idx=0, o_bpm=BPM_DEFAULT, o_bpm_counter=PERIOD_DEFAULT (CLK_HZ*60/BPM_DEFAULT, elaboration-time constant), o_busy=0, pending=0, state STOP.
REQ-032 Reset mid-division aborts the division; no stale result is applied after release.

Structure
REQ-033 Package metronome_pkg holds the state enum, BPM_STEP_SMALL=1, BPM_STEP_LARGE=5, the PERIOD_DEFAULT function, and the 9-bit bpm width constant.
REQ-034 Sub-module seq_divider (CNT_W-bit unsigned restoring, start/done/busy handshake); all else in metronome_bar.

Verification (CLK_HZ=1000, defaults otherwise)
REQ-035 Reset, i_run=1 -> first trigger+accent at cycle 1, then triggers every 500 cycles; o_bpm_counter=500.
REQ-036 i_beats_sel=4 -> accent on every 4th trigger; change to 3 mid-bar -> takes effect at next beat 0 only.
REQ-037 i_bpm_minus_5 x18 from 120 -> o_bpm=30 (saturated), o_bpm_counter=2000 after next beat boundary; plus_5 at 300 -> remains 300, period 200.
REQ-038 Plus_1 pulse then plus_5 pulse 3 cycles later -> o_busy spans both computations; final o_bpm_counter=476 (60000/126); 495 (60000/121) never applied.
REQ-039 Plus_1 and minus_5 in same cycle -> o_bpm=121.
REQ-040 i_reset_n low during o_busy, at phase 250 -> all outputs at reset values; after release, period=500 and no spurious trigger.

Source files
------------

// File: rtl/metronome_pkg.sv
// Shared types and constants for the metronome_bar block.
//   state_e        : metronome run state (stopped / running)
//   BPM_W          : width of the tempo value
//   BPM_STEP_SMALL : tempo change for a +1 / -1 button
//   BPM_STEP_LARGE : tempo change for a +5 / -5 button
//   period_default : beat period in clock cycles for a given clock and tempo
package metronome_pkg;

  typedef enum logic [0:0] {
    StStop,
    StRun
  } state_e;

  localparam int unsigned BPM_W          = 9;
  localparam int unsigned BPM_STEP_SMALL = 1;
  localparam int unsigned BPM_STEP_LARGE = 5;

  // Clock cycles per beat: clk_hz * 60 / bpm, floored.
  function automatic longint unsigned period_default(input longint unsigned clk_hz,
                                                     input longint unsigned bpm);
    return (clk_hz * 64'd60) / bpm;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset, aborts any division in flight
//   start_i    : load operands and begin; accepted when idle or on the done cycle
//   dividend_i : W-bit dividend
//   divisor_i  : W-bit divisor (must be non-zero)
//   busy_o     : high from the cycle after start until and including done
//   done_o     : one-cycle pulse, W+1 cycles after start; quotient_o valid then
//   quotient_o : floor(dividend / divisor)
module seq_divider #(
  parameter int unsigned W = 34
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] quotient_o
);

  localparam int unsigned CntW = $clog2(W + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(W);

  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    div_q, div_d;
  logic [W:0]      rem_shift;
  logic [W:0]      rem_sub;
  logic            fits;

  always_comb begin
    // Shift next dividend bit into the partial remainder, then try to subtract.
    rem_shift = {rem_q, quo_q[W-1]};
    rem_sub   = rem_shift - {1'b0, div_q};
    fits      = rem_shift >= {1'b0, div_q};
    done_o    = busy_q && (cnt_q == LastStep);

    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;

    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend_i;
      div_d  = divisor_i;
    end else if (busy_q) begin
      if (cnt_q == LastStep) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
        // The remainder stays below the divisor, so W bits always hold it.
        rem_d = fits ? W'(rem_sub) : W'(rem_shift);
        quo_d = {quo_q[W-2:0], fits};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
    end
  end

  assign busy_o     = busy_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/metronome_bar.sv
// Bar-aware metronome with button-stepped tempo.
//   i_clk, i_reset_n   : clock, asynchronous active-low reset
//   i_run              : level, 1 = running
//   i_bpm_plus_1/5, i_bpm_minus_1/5 : single-cycle tempo step pulses
//   i_beats_sel        : requested beats per bar (0 -> 1, clamped to BEATS_MAX)
//   o_trigger          : one-cycle pulse per beat
//   o_accent           : one-cycle pulse with o_trigger on beat 0
//   o_beat_idx         : current beat within the bar
//   o_bpm              : current tempo
//   o_bpm_counter      : beat period in use, in clock cycles
//   o_busy             : period recomputation in progress
module metronome_bar
  import metronome_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned BPM_MIN     = 30,
  parameter int unsigned BPM_MAX     = 300,
  parameter int unsigned BPM_DEFAULT = 120,
  parameter int unsigned BEATS_MAX   = 8,
  parameter int unsigned CNT_W       = 34
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_run,
  input  logic             i_bpm_plus_1,
  input  logic             i_bpm_plus_5,
  input  logic             i_bpm_minus_1,
  input  logic             i_bpm_minus_5,
  input  logic [3:0]       i_beats_sel,
  output logic             o_trigger,
  output logic             o_accent,
  output logic [3:0]       o_beat_idx,
  output logic [BPM_W-1:0] o_bpm,
  output logic [CNT_W-1:0] o_bpm_counter,
  output logic             o_busy
);

  localparam logic [BPM_W:0]   BpmMaxX = (BPM_W + 1)'(BPM_MAX);
  localparam logic [BPM_W:0]   BpmMinX = (BPM_W + 1)'(BPM_MIN);
  localparam logic [BPM_W-1:0] BpmMax  = BPM_W'(BPM_MAX);
  localparam logic [BPM_W-1:0] BpmMin  = BPM_W'(BPM_MIN);
  localparam logic [BPM_W-1:0] BpmDef  = BPM_W'(BPM_DEFAULT);
  localparam logic [BPM_W:0]   StepS   = (BPM_W + 1)'(BPM_STEP_SMALL);
  localparam logic [BPM_W:0]   StepL   = (BPM_W + 1)'(BPM_STEP_LARGE);

  localparam logic [63:0]      DividendFull  = 64'(CLK_HZ) * 64'd60;
  localparam logic [CNT_W-1:0] Dividend      = DividendFull[CNT_W-1:0];
  localparam logic [CNT_W-1:0] PeriodDefault =
      CNT_W'(period_default(64'(CLK_HZ), 64'(BPM_DEFAULT)));

  function automatic logic [3:0] sanitize_beats(input logic [3:0] sel);
    if (sel == 4'd0) begin
      return 4'd1;
    end else if (32'(sel) > BEATS_MAX) begin
      return 4'(BEATS_MAX);
    end
    return sel;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       beats_q, beats_d;
  logic             trig_q, trig_d;
  logic             acc_q, acc_d;
  logic             beat_wrap;

  logic [BPM_W-1:0] bpm_q, bpm_d;
  logic [BPM_W:0]   bpm_x, bpm_sum, step_amt;
  logic             step_up, step_dn, bpm_changed;

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] staged_q, staged_d;
  logic             staged_valid_q, staged_valid_d;
  logic             pending_q, pending_d;

  logic             div_start, div_busy, div_done, result_take;
  logic [CNT_W-1:0] div_quotient;

  // Tempo stepping: highest-priority button wins, saturating at the limits.
  always_comb begin
    bpm_x    = {1'b0, bpm_q};
    step_up  = 1'b0;
    step_dn  = 1'b0;
    step_amt = StepS;
    if (i_bpm_plus_5) begin
      step_up  = 1'b1;
      step_amt = StepL;
    end else if (i_bpm_plus_1) begin
      step_up  = 1'b1;
    end else if (i_bpm_minus_5) begin
      step_dn  = 1'b1;
      step_amt = StepL;
    end else if (i_bpm_minus_1) begin
      step_dn  = 1'b1;
    end
    bpm_sum = bpm_x + step_amt;

    bpm_d = bpm_q;
    if (step_up) begin
      bpm_d = (bpm_sum > BpmMaxX) ? BpmMax : bpm_sum[BPM_W-1:0];
    end else if (step_dn) begin
      bpm_d = (bpm_x < BpmMinX + step_amt) ? BpmMin : BPM_W'(bpm_x - step_amt);
    end
    bpm_changed = (bpm_d != bpm_q);
  end

  // Divider control: a change during a division only marks it stale; the divider
  // restarts on its done cycle with the newest tempo and the stale quotient is dropped.
  always_comb begin
    div_start   = (bpm_changed && !div_busy) || (div_done && (pending_q || bpm_changed));
    result_take = div_done && !pending_q && !bpm_changed;
    pending_d   = pending_q;
    if (div_done) begin
      pending_d = 1'b0;
    end else if (bpm_changed && div_busy) begin
      pending_d = 1'b1;
    end
  end

  seq_divider #(
    .W (CNT_W)
  ) u_divider (
    .clk_i      (i_clk),
    .rst_ni     (i_reset_n),
    .start_i    (div_start),
    .dividend_i (Dividend),
    .divisor_i  ({{(CNT_W - BPM_W){1'b0}}, bpm_d}),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quotient)
  );

  // Run/stop sequencing and beat counting.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    beats_d   = beats_q;
    trig_d    = 1'b0;
    acc_d     = 1'b0;
    beat_wrap = 1'b0;

    unique case (state_q)
      StStop: begin
        phase_d = '0;
        idx_d   = '0;
        beats_d = sanitize_beats(i_beats_sel);
        if (i_run) begin
          state_d = StRun;
          trig_d  = 1'b1;
          acc_d   = 1'b1;
        end
      end
      StRun: begin
        if (!i_run) begin
          state_d = StStop;
          phase_d = '0;
          idx_d   = '0;
        end else if (phase_q == period_q - CNT_W'(1)) begin
          phase_d   = '0;
          trig_d    = 1'b1;
          beat_wrap = 1'b1;
          if (idx_q == beats_q - 4'd1) begin
            // Bar boundary: the only point where a new bar length is taken.
            idx_d   = '0;
            acc_d   = 1'b1;
            beats_d = sanitize_beats(i_beats_sel);
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      default: state_d = StStop;
    endcase
  end

  // New periods wait in the staging register so a beat never changes length mid-way.
  always_comb begin
    period_d       = period_q;
    staged_d       = staged_q;
    staged_valid_d = staged_valid_q;
    if (staged_valid_q && (state_q == StStop || beat_wrap)) begin
      period_d       = staged_q;
      staged_valid_d = 1'b0;
    end
    if (result_take) begin
      if (state_q == StStop) begin
        period_d       = div_quotient;
        staged_valid_d = 1'b0;
      end else begin
        staged_d       = div_quotient;
        staged_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= StStop;
      phase_q        <= '0;
      idx_q          <= '0;
      beats_q        <= 4'd1;
      trig_q         <= 1'b0;
      acc_q          <= 1'b0;
      bpm_q          <= BpmDef;
      period_q       <= PeriodDefault;
      staged_q       <= PeriodDefault;
      staged_valid_q <= 1'b0;
      pending_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      idx_q          <= idx_d;
      beats_q        <= beats_d;
      trig_q         <= trig_d;
      acc_q          <= acc_d;
      bpm_q          <= bpm_d;
      period_q       <= period_d;
      staged_q       <= staged_d;
      staged_valid_q <= staged_valid_d;
      pending_q      <= pending_d;
    end
  end

  // Dropping i_run silences the pulses in the same cycle.
  assign o_trigger     = trig_q && i_run;
  assign o_accent      = acc_q && i_run;
  assign o_beat_idx    = idx_q;
  assign o_bpm         = bpm_q;
  assign o_bpm_counter = period_q;
  assign o_busy        = div_busy;

endmodule
